// File: rtl/beta_pkg.sv
// Shared definitions for the Beta register file, its decode stage and the
// register-file controller.
package beta_pkg;

    // Architectural register count; the top register is hardwired to zero.
    localparam int NREGS = 32;

    // Address of the hardwired-zero register.
    localparam logic [4:0] R_ZERO = 5'd31;

    // Register-file controller sequencing states.
    typedef enum logic [2:0] {
        CLEAR,
        RUN,
        DRAIN,
        ACCESS,
        RESP
    } rf_ctrl_state_t;

endpackage

// File: rtl/reg_file_ctrl.sv
// Register-file controller: owns the write port of the 32x32 Beta register
// file. Zeroes R0..R30 after reset, then forwards pipeline write-back, and
// services a debug port by halting the pipeline, draining in-flight writes
// and borrowing read/write port 1 for one access.
module reg_file_ctrl #(
    parameter int NREGS        = beta_pkg::NREGS,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,

    // Pipeline write-back
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,

    // Debug port
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,

    // Pipeline control / status
    output logic          halt,
    output logic          init_done,

    // Register-file port
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          rf_ra_sel,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_rd1
);

    import beta_pkg::*;

    // The drain counter only has to hold DRAIN_CYCLES-1.
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Last index written by the clear walk; the zero register is skipped.
    localparam logic [AW-1:0]  CLR_LAST   = AW'(NREGS - 2);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    rf_ctrl_state_t  state;
    logic [AW-1:0]   clr_idx;
    logic [DCW-1:0]  drain_cnt;

    // Sequencer: state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            drain_cnt <= '0;
            halt      <= 1'b1;
            init_done <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            // The acknowledge is a single-cycle pulse raised only on ACCESS exit.
            dbg_ack <= 1'b0;

            case (state)
                CLEAR: begin
                    // Write-back and debug requests are ignored until the walk ends.
                    if (clr_idx == CLR_LAST) begin
                        state     <= RUN;
                        halt      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end

                RUN: begin
                    if (dbg_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        halt      <= 1'b1;
                    end
                end

                DRAIN: begin
                    // Fetch is frozen; let the exec/mem/wb stages retire.
                    if (drain_cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end

                ACCESS: begin
                    // A late write-back owns the port; retry the access next cycle.
                    if (!wb_we) begin
                        if (!dbg_we) begin
                            dbg_rdata <= rf_rd1;
                        end
                        dbg_ack <= 1'b1;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    // halt falls together with the return to RUN.
                    state <= RUN;
                    halt  <= 1'b0;
                end

                default: begin
                    state     <= CLEAR;
                    clr_idx   <= '0;
                    halt      <= 1'b1;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Register-file port mux: clear walk, write-back passthrough or debug access.
    always_comb begin
        rf_we     = 1'b0;
        rf_wa     = wb_wa;
        rf_wd     = wb_wd;
        rf_ra_sel = 1'b0;
        rf_ra     = dbg_addr;

        case (state)
            CLEAR: begin
                rf_we = 1'b1;
                rf_wa = clr_idx;
                rf_wd = '0;
            end

            RUN, DRAIN, RESP: begin
                rf_we = wb_we;
            end

            ACCESS: begin
                if (wb_we) begin
                    rf_we = 1'b1;
                end else if (dbg_we) begin
                    // R31 is still presented; the register file drops the write.
                    rf_we = 1'b1;
                    rf_wa = dbg_addr;
                    rf_wd = dbg_wdata;
                end else begin
                    rf_ra_sel = 1'b1;
                end
            end

            default: begin
                rf_we = 1'b0;
            end
        endcase

        // Nothing touches the register file while reset is asserted.
        if (rst) begin
            rf_we     = 1'b0;
            rf_ra_sel = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Testbench for reg_file_ctrl: a behavioural register file sits on the port,
// an abstract register model tracks expected contents, and a scoreboard
// queue of expected debug acknowledges is drained by an independent monitor.
module tb_reg_file_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          halt;
    logic          init_done;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          rf_ra_sel;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_rd1;

    reg_file_ctrl #(
        .NREGS(32), .AW(AW), .DW(DW), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .halt(halt), .init_done(init_done),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_ra_sel(rf_ra_sel), .rf_ra(rf_ra), .rf_rd1(rf_rd1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        int          ack_cyc;
    } ack_exp_t;

    ack_exp_t    sb[$];
    logic [31:0] model [32];
    logic [31:0] env_rf[32];
    logic [31:0] last_rd;
    ack_exp_t    mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural register file: R31 reads zero, port 1 answers the controller when selected.
    initial for (int i = 0; i < 32; i++) env_rf[i] <= $urandom;
    always @(posedge clk) if (rf_we && rf_wa != 5'd31) env_rf[rf_wa] <= rf_wd;
    always_comb begin
        if (rf_ra_sel) rf_rd1 = (rf_ra == 5'd31) ? 32'd0 : env_rf[rf_ra];
        else           rf_rd1 = 32'hFFFF_FFFF;
    end

    // Ack monitor: every acknowledge must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            last_rd = 32'd0;
        end else if (dbg_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                if (mon_e.is_read) begin
                    chk("dbg_rdata", dbg_rdata, mon_e.rdata);
                    last_rd = mon_e.rdata;
                end else begin
                    chk("rdata_held", dbg_rdata, last_rd);
                end
            end
        end
    end

    function automatic logic [4:0] other_addr(input logic [4:0] avoid);
        logic [4:0] a;
        a = 5'($urandom_range(30, 0));
        if (a == avoid) a = (a == 5'd30) ? 5'd0 : a + 5'd1;
        return a;
    endfunction

    // Starts at posedge+1 of the first clear cycle, ends at the negedge of the first RUN cycle.
    task automatic check_clear();
        for (int i = 0; i < 31; i++) begin
            wb_we = 1'($urandom_range(1, 0));
            wb_wa = 5'($urandom);
            wb_wd = $urandom;
            @(negedge clk);
            chk("clr_we", 32'(rf_we), 32'd1);
            chk("clr_wa", 32'(rf_wa), 32'(i));
            chk("clr_wd", rf_wd, 32'd0);
            chk("clr_halt", 32'(halt), 32'd1);
            chk("clr_init", 32'(init_done), 32'd0);
            @(posedge clk); #1;
        end
        wb_we = 1'b0;
        @(negedge clk);
        chk("init_done", 32'(init_done), 32'd1);
        chk("run_halt", 32'(halt), 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wb_we = 1'b1; wb_wa = a; wb_wd = d;
        @(negedge clk);
        chk("run_pass_we", 32'(rf_we), 32'd1);
        chk("run_pass_wa", 32'(rf_wa), 32'(a));
        chk("run_pass_wd", rf_wd, d);
        if (a != 5'd31) model[a] = d;
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    task automatic dbg_txn(input bit we, input logic [4:0] addr, input logic [31:0] wd, input int n_stray);
        int t0, t_ack;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; wb_we = 1'b0;
        t0    = cyc;
        t_ack = t0 + DRAIN + 2 + n_stray;
        exp_rd = (addr == 5'd31) ? 32'd0 : model[addr];
        sb.push_back('{!we, exp_rd, t_ack});
        if (we && addr != 5'd31) model[addr] = wd;
        while (cyc <= t_ack + 1) begin
            if (cyc == t_ack + 1) dbg_req = 1'b0;
            wb_we = 1'b0;
            if ((cyc >= t0 + 1 && cyc <= t0 + DRAIN && $urandom_range(1, 0) == 1) ||
                (cyc >= t0 + DRAIN + 1 && cyc <= t0 + DRAIN + n_stray)) begin
                wb_we = 1'b1;
                wb_wa = other_addr(addr);
                wb_wd = $urandom;
                model[wb_wa] = wb_wd;
            end
            @(negedge clk);
            chk("txn_halt", 32'(halt), 32'(cyc > t0 && cyc <= t_ack));
            if (wb_we) begin
                chk("txn_pass_we", 32'(rf_we), 32'd1);
                chk("txn_pass_wa", 32'(rf_wa), 32'(wb_wa));
                chk("txn_pass_wd", rf_wd, wb_wd);
            end
            if (cyc == t0 + DRAIN + 1 + n_stray) begin
                if (we) begin
                    chk("dbg_wr_we", 32'(rf_we), 32'd1);
                    chk("dbg_wr_wa", 32'(rf_wa), 32'(addr));
                    chk("dbg_wr_wd", rf_wd, wd);
                end else begin
                    chk("dbg_rd_sel", 32'(rf_ra_sel), 32'd1);
                    chk("dbg_rd_ra", 32'(rf_ra), 32'(addr));
                    chk("dbg_rd_we", 32'(rf_we), 32'd0);
                end
            end
            @(posedge clk); #1;
        end
        wb_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int t0;
        rst = 1'b1;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        // Debug read of R3 held from reset: serviced only after init, then back-to-back.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3; dbg_wdata = '0;

        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_halt", 32'(halt), 32'd1);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_ra_sel", 32'(rf_ra_sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        sb.push_back('{1'b1, 32'd0, c0 + 31 + DRAIN + 2});
        sb.push_back('{1'b1, 32'd0, c0 + 31 + 2 * (DRAIN + 2) + 1});
        check_clear();
        while (cyc < c0 + 31 + 2 * (DRAIN + 2) + 2) begin
            @(negedge clk);
            chk("b2b_halt", 32'(halt),
                32'((cyc >= c0 + 32 && cyc <= c0 + 31 + DRAIN + 2) ||
                    (cyc >= c0 + 31 + DRAIN + 4 && cyc <= c0 + 31 + 2 * (DRAIN + 2) + 1)));
            @(posedge clk); #1;
        end
        dbg_req = 1'b0;

        // Write then read back through the debug port.
        wb_write(5'd7, 32'h0000_0077);
        dbg_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 0);
        dbg_txn(1'b0, 5'd5, 32'd0, 0);

        // R31 write is dropped, read returns zero.
        dbg_txn(1'b1, 5'd31, 32'h0000_1234, 0);
        dbg_txn(1'b0, 5'd31, 32'd0, 0);

        // Stray write-back in ACCESS delays the acknowledge.
        dbg_txn(1'b1, 5'd9, 32'hCAFE_F00D, 1);
        dbg_txn(1'b0, 5'd9, 32'd0, 2);
        dbg_txn(1'b0, 5'd7, 32'd0, 0);

        // Reset in the middle of DRAIN aborts the access and restarts the clear.
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h1010_1010;
        t0 = cyc;
        while (cyc < t0 + 2) begin @(posedge clk); #1; end
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        chk("abort_halt", 32'(halt), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_rst_we", 32'(rf_we), 32'd0);
        chk("abort_rst_halt", 32'(halt), 32'd1);
        chk("abort_rst_init", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_clear();

        // Randomized mix of write-back and debug traffic.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(2, 0) == 0)
                wb_write(5'($urandom), $urandom);
            else
                dbg_txn(1'($urandom_range(1, 0)), 5'($urandom), $urandom, int'($urandom_range(2, 0)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 31; i++) chk("rf_contents", env_rf[i], model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
